hpm_ovf_irq: RTL and testbench

Local-counter-overflow (LCOFI) interrupt controller for the Sscofpmf extension, directly downstream of `hpm_counters`. It consumes the overflow request pulse and per-counter OF bits from `hpm_counters` and maintains the LCOFIP pending bit (mip/sip bit 13). It serves the `scountovf` CSR and a custom coalesced-overflow counter CSR, and drives a registered interrupt request into the core's trap logic.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/hpm_ovf_irq.sv | 152 +++++++++++++++
 tb/tb_hpm_ovf_irq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V privilege, CSR address and LCOFI definitions for the CSR slice.
package riscv_pkg;

  localparam logic [1:0] PRIV_LVL_U = 2'b00;
  localparam logic [1:0] PRIV_LVL_S = 2'b01;
  localparam logic [1:0] PRIV_LVL_M = 2'b11;

  localparam logic [11:0] CSR_SIP          = 12'h144;
  localparam logic [11:0] CSR_MIP          = 12'h344;
  localparam logic [11:0] CSR_HPM_OVF_COAL = 12'h7C0;
  localparam logic [11:0] CSR_SCOUNTOVF    = 12'hDA0;

  localparam int unsigned LCOFI_BIT = 13;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } hpm_ovf_state_t;

endpackage

// File: rtl/hpm_ovf_irq.sv
// Sscofpmf local-counter-overflow interrupt controller: LCOFIP state, scountovf
// read port and a saturating coalesced-overflow counter at CSR 0x7C0.
module hpm_ovf_irq
  import riscv_pkg::*;
#(
  parameter int unsigned CSR_ADDR_WIDTH   = 12,
  parameter int unsigned XLEN             = 64,
  parameter int unsigned HPM_NUM_COUNTERS = 29,
  parameter int unsigned COAL_CNT_WIDTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CSR_ADDR_WIDTH-1:0]     addr_i,
  input  logic                          we_i,
  input  logic [XLEN-1:0]               data_i,
  output logic [XLEN-1:0]               data_o,
  output logic                          illegal_o,
  input  logic [1:0]                    priv_lvl_i,
  input  logic                          count_ovf_int_req_i,
  input  logic [HPM_NUM_COUNTERS+2:3]   mhpm_ovf_bits_i,
  input  logic [31:0]                   mcounteren_i,
  input  logic                          mie_lcofie_i,
  input  logic                          mideleg_lcofi_i,
  output logic                          lcofip_o,
  output logic                          irq_o,
  output logic                          irq_s_o
);

  localparam int unsigned OVF_VEC_W = 32;

  if (XLEN != 64) begin : g_xlen_chk
    $error("hpm_ovf_irq: only XLEN=64 is supported");
  end
  if (HPM_NUM_COUNTERS > 29) begin : g_hpm_chk
    $error("hpm_ovf_irq: HPM_NUM_COUNTERS must not exceed 29");
  end

  hpm_ovf_state_t            state_q;
  logic [COAL_CNT_WIDTH-1:0] coal_q;
  logic                      irq_q;
  logic                      irq_s_q;

  logic                      is_mip;
  logic                      is_sip;
  logic                      is_coal;
  logic                      is_scountovf;
  logic                      priv_m;
  logic                      priv_s;
  logic                      sw_wr;
  logic                      sw_bit;
  logic                      set_req;
  logic                      clr_req;
  logic                      coal_clr;
  logic                      coal_sat;
  logic [OVF_VEC_W-1:0]      ovf_vec;

  // Address / privilege decode shared by the write and read paths
  always_comb begin
    is_mip       = (addr_i == CSR_ADDR_WIDTH'(CSR_MIP));
    is_sip       = (addr_i == CSR_ADDR_WIDTH'(CSR_SIP));
    is_coal      = (addr_i == CSR_ADDR_WIDTH'(CSR_HPM_OVF_COAL));
    is_scountovf = (addr_i == CSR_ADDR_WIDTH'(CSR_SCOUNTOVF));
    priv_m       = (priv_lvl_i == PRIV_LVL_M);
    priv_s       = (priv_lvl_i == PRIV_LVL_S);
  end

  // Software LCOFIP writes: sip only reaches bit 13 when LCOFI is delegated
  always_comb begin
    sw_wr    = we_i && ((is_mip && priv_m) ||
                        (is_sip && (priv_m || priv_s) && mideleg_lcofi_i));
    sw_bit   = data_i[LCOFI_BIT];
    set_req  = count_ovf_int_req_i || (sw_wr && sw_bit);
    clr_req  = sw_wr && !sw_bit;
    coal_clr = we_i && is_coal && priv_m;
    coal_sat = &coal_q;
  end

  // LCOFIP FSM; irq outputs follow the next state so they rise with lcofip_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      irq_s_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= set_req ? PEND : IDLE;
          irq_q   <= set_req && mie_lcofie_i;
          irq_s_q <= set_req && mie_lcofie_i && mideleg_lcofi_i;
        end
        PEND: begin
          // An overflow pulse beats a simultaneous software clear
          state_q <= (count_ovf_int_req_i || !clr_req) ? PEND : IDLE;
          irq_q   <= (count_ovf_int_req_i || !clr_req) && mie_lcofie_i;
          irq_s_q <= (count_ovf_int_req_i || !clr_req) && mie_lcofie_i
                     && mideleg_lcofi_i;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
          irq_s_q <= 1'b0;
        end
      endcase
    end
  end

  // Coalesced-overflow counter: software clear dominates a same-cycle increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      coal_q <= '0;
    end else if (coal_clr) begin
      coal_q <= '0;
    end else if (count_ovf_int_req_i && (state_q == PEND) && !coal_sat) begin
      coal_q <= coal_q + COAL_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    ovf_vec = '0;
    ovf_vec[HPM_NUM_COUNTERS+2:3] = mhpm_ovf_bits_i;
  end

  // CSR read mux and privilege checks, side-effect free
  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    if (is_scountovf) begin
      if (we_i || !(priv_m || priv_s)) begin
        illegal_o = 1'b1;
      end else if (priv_m) begin
        data_o = XLEN'(ovf_vec);
      end else begin
        data_o = XLEN'(ovf_vec & mcounteren_i);
      end
    end else if (is_coal) begin
      if (!priv_m) begin
        illegal_o = 1'b1;
      end else begin
        data_o = XLEN'(coal_q);
      end
    end
  end

  assign lcofip_o = (state_q == PEND);
  assign irq_o    = irq_q;
  assign irq_s_o  = irq_s_q;

  // Only bit 13 of write data is meaningful to this block
  logic unused_data;
  assign unused_data = ^{data_i[XLEN-1:LCOFI_BIT+1], data_i[LCOFI_BIT-1:0]};

endmodule

// File: tb/tb_hpm_ovf_irq.sv
// Directed self-checking bench for hpm_ovf_irq.
module tb_hpm_ovf_irq;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        we;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        illegal;
  logic [1:0]  priv;
  logic        ovf_req;
  logic [31:3] ovf_bits;
  logic [31:0] mcounteren;
  logic        lcofie;
  logic        deleg;
  logic        lcofip;
  logic        irq;
  logic        irq_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hpm_ovf_irq dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .addr_i              (addr),
    .we_i                (we),
    .data_i              (wdata),
    .data_o              (rdata),
    .illegal_o           (illegal),
    .priv_lvl_i          (priv),
    .count_ovf_int_req_i (ovf_req),
    .mhpm_ovf_bits_i     (ovf_bits),
    .mcounteren_i        (mcounteren),
    .mie_lcofie_i        (lcofie),
    .mideleg_lcofi_i     (deleg),
    .lcofip_o            (lcofip),
    .irq_o               (irq),
    .irq_s_o             (irq_s)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_idle();
    we    = 1'b0;
    addr  = 12'h000;
    wdata = '0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [63:0] d, input logic [1:0] p);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    priv  = p;
    step();
    csr_idle();
    #1;
  endtask

  task automatic csr_read(input logic [11:0] a, input logic [1:0] p,
                          input logic [63:0] exp_d, input logic exp_ill, input string tag);
    addr = a;
    priv = p;
    we   = 1'b0;
    #1;
    chk({tag, "_data"}, rdata, exp_d);
    chk({tag, "_ill"}, 64'(illegal), 64'(exp_ill));
    csr_idle();
    priv = PRIV_LVL_M;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    csr_idle();
    priv       = PRIV_LVL_M;
    ovf_req    = 1'b0;
    ovf_bits   = '0;
    mcounteren = '0;
    lcofie     = 1'b1;
    deleg      = 1'b0;
    step();
    step();
    rst = 1'b0;

    // 1. reset state and first overflow
    chk("rst_lcofip", 64'(lcofip), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_irq_s", 64'(irq_s), 64'd0);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd0, 1'b0, "rst_coal");
    ovf_req = 1'b1;
    step();
    ovf_req = 1'b0;
    chk("ovf1_lcofip", 64'(lcofip), 64'd1);
    chk("ovf1_irq", 64'(irq), 64'd1);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd0, 1'b0, "ovf1_coal");

    // 2. coalescing and saturation
    ovf_req = 1'b1;
    repeat (300) step();
    ovf_req = 1'b0;
    chk("sat_lcofip", 64'(lcofip), 64'd1);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd255, 1'b0, "sat_coal");
    csr_write(CSR_HPM_OVF_COAL, 64'hFFFF_FFFF_FFFF_FFFF, PRIV_LVL_M);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd0, 1'b0, "coal_clr");

    // 3. set-wins race: clear and pulse in the same cycle
    ovf_req = 1'b1;
    csr_write(CSR_MIP, 64'd0, PRIV_LVL_M);
    ovf_req = 1'b0;
    chk("race_lcofip", 64'(lcofip), 64'd1);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd1, 1'b0, "race_coal");

    // plain clear, software set, and LCOFIE gating
    csr_write(CSR_MIP, 64'd0, PRIV_LVL_M);
    chk("mipclr_lcofip", 64'(lcofip), 64'd0);
    chk("mipclr_irq", 64'(irq), 64'd0);
    csr_write(CSR_MIP, 64'h2000, PRIV_LVL_M);
    chk("mipset_lcofip", 64'(lcofip), 64'd1);
    chk("mipset_irq", 64'(irq), 64'd1);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd1, 1'b0, "mipset_coal");
    lcofie = 1'b0;
    step();
    chk("ie_off_irq", 64'(irq), 64'd0);
    chk("ie_off_lcofip", 64'(lcofip), 64'd1);
    lcofie = 1'b1;
    step();
    chk("ie_on_irq", 64'(irq), 64'd1);

    // 4. scountovf masking and privilege
    ovf_bits = '0;
    ovf_bits[3]  = 1'b1;
    ovf_bits[5]  = 1'b1;
    ovf_bits[31] = 1'b1;
    mcounteren = 32'h20;
    #1;
    csr_read(CSR_SCOUNTOVF, PRIV_LVL_S, 64'h20, 1'b0, "sovf_s");
    csr_read(CSR_SCOUNTOVF, PRIV_LVL_M, 64'h8000_0028, 1'b0, "sovf_m");
    csr_read(CSR_SCOUNTOVF, PRIV_LVL_U, 64'd0, 1'b1, "sovf_u");
    addr = CSR_SCOUNTOVF; wdata = '0; we = 1'b1; priv = PRIV_LVL_M;
    #1;
    chk("sovf_wr_ill", 64'(illegal), 64'd1);
    step();
    csr_idle();
    chk("sovf_wr_lcofip", 64'(lcofip), 64'd1);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_S, 64'd0, 1'b1, "coal_s");
    csr_read(12'h300, PRIV_LVL_M, 64'd0, 1'b0, "other");

    // 5. delegation of sip writes
    deleg = 1'b0;
    csr_write(CSR_SIP, 64'd0, PRIV_LVL_S);
    chk("nodeleg_lcofip", 64'(lcofip), 64'd1);
    chk("nodeleg_irq_s", 64'(irq_s), 64'd0);
    deleg = 1'b1;
    step();
    chk("deleg_irq_s", 64'(irq_s), 64'd1);
    csr_write(CSR_SIP, 64'd0, PRIV_LVL_S);
    chk("deleg_lcofip", 64'(lcofip), 64'd0);
    chk("deleg_irq_s_fall", 64'(irq_s), 64'd0);
    priv = PRIV_LVL_M;

    // 6. reset mid-operation with a simultaneous pulse
    ovf_req = 1'b1;
    step();
    step();
    chk("pre_rst_lcofip", 64'(lcofip), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ovf_req = 1'b0;
    #1;
    chk("mid_rst_lcofip", 64'(lcofip), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    chk("mid_rst_irq_s", 64'(irq_s), 64'd0);
    csr_read(CSR_HPM_OVF_COAL, PRIV_LVL_M, 64'd0, 1'b0, "mid_rst_coal");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
